// File: rtl/bbox_overlay_pkg.sv
// Shared constants and types for the bounding-box overlay.
// Holds frame geometry, FSM state encoding and the pixel/box types.
package bbox_overlay_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef logic [11:0] rgb444_t;

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
    logic [9:0] top;
    logic [9:0] bottom;
  } box_t;

  function automatic logic box_valid(box_t b);
    return (b.left < b.right) && (b.top < b.bottom) &&
           (b.right <= X_LAST) && (b.bottom <= Y_LAST);
  endfunction

endpackage

// File: rtl/bbox_capture.sv
// Frame-end capture of the incoming box, shadow register and
// IDLE/TRACK/HOLD tracking FSM with a bounded miss counter.
module bbox_capture
  import bbox_overlay_pkg::*;
#(
  parameter int HOLD_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic [9:0] i_pixel_x,
  input  logic [9:0] i_pixel_y,
  input  box_t       i_box,
  output box_t       o_shadow,
  output logic       o_active,
  output logic [3:0] o_miss_cnt
);

  localparam logic [4:0] HOLD_LIM = 5'(HOLD_FRAMES);

  logic       w_frame_end;
  logic       w_valid;
  logic       w_miss_full;
  logic [1:0] w_state_nx;
  logic [3:0] w_miss_nx;

  logic [1:0] r_state;
  logic [3:0] r_miss;
  logic       r_active;
  box_t       r_shadow;

  assign w_frame_end = (i_pixel_x == X_LAST) && (i_pixel_y == Y_LAST);
  assign w_valid     = box_valid(i_box);
  assign w_miss_full = ({1'b0, r_miss} + 5'd1) >= HOLD_LIM;

  // Next-state and miss counter; only frame end can move the FSM.
  always_comb begin
    w_state_nx = r_state;
    w_miss_nx  = r_miss;
    if (w_frame_end) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            w_state_nx = ST_TRACK;
            w_miss_nx  = 4'd0;
          end
        end
        ST_TRACK: begin
          if (!w_valid) begin
            if (HOLD_LIM <= 5'd1) begin
              w_state_nx = ST_IDLE;
              w_miss_nx  = 4'd0;
            end else begin
              w_state_nx = ST_HOLD;
              w_miss_nx  = 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (w_valid) begin
            w_state_nx = ST_TRACK;
            w_miss_nx  = 4'd0;
          end else if (w_miss_full) begin
            w_state_nx = ST_IDLE;
            w_miss_nx  = 4'd0;
          end else begin
            w_miss_nx  = r_miss + 4'd1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_miss_nx  = 4'd0;
        end
      endcase
    end
  end

  // State, activity flag and shadow box; shadow only takes valid boxes.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_miss          <= 4'd0;
      r_active        <= 1'b0;
      r_shadow.left   <= 10'd0;
      r_shadow.right  <= X_LAST;
      r_shadow.top    <= 10'd0;
      r_shadow.bottom <= Y_LAST;
    end else begin
      r_state  <= w_state_nx;
      r_miss   <= w_miss_nx;
      r_active <= (w_state_nx != ST_IDLE);
      if (w_frame_end && w_valid) begin
        r_shadow <= i_box;
      end
    end
  end

  assign o_shadow   = r_shadow;
  assign o_active   = r_active;
  assign o_miss_cnt = r_miss;

endmodule

// File: rtl/bbox_overlay.sv
// Draws a tracked bounding-box outline over the VGA pixel stream.
// Optional crosshair at box centre: define BBOX_OVERLAY_CROSSHAIR_EN.
module bbox_overlay
  import bbox_overlay_pkg::*;
#(
  parameter int          LINE_W      = 2,
  parameter logic [11:0] BOX_COLOR   = 12'hF00,
  parameter int          HOLD_FRAMES = 8
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [11:0] img_data,
  input  logic [9:0]  left,
  input  logic [9:0]  right,
  input  logic [9:0]  top,
  input  logic [9:0]  bottom,
  output logic [11:0] out_data,
  output logic        box_active,
  output logic [3:0]  miss_cnt
);

  localparam logic [10:0] LW = 11'(LINE_W);

  box_t        w_box;
  box_t        w_shadow;
  logic        w_active;
  logic [3:0]  w_miss;
  logic [10:0] w_x, w_y, w_l, w_r, w_t, w_b;
  logic        w_in_box;
  logic        w_edge;
  logic        w_paint;
  rgb444_t     r_out;

  assign w_box = {left, right, top, bottom};

  bbox_capture #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_capture (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .i_pixel_x (pixel_x),
    .i_pixel_y (pixel_y),
    .i_box     (w_box),
    .o_shadow  (w_shadow),
    .o_active  (w_active),
    .o_miss_cnt(w_miss)
  );

  assign w_x = {1'b0, pixel_x};
  assign w_y = {1'b0, pixel_y};
  assign w_l = {1'b0, w_shadow.left};
  assign w_r = {1'b0, w_shadow.right};
  assign w_t = {1'b0, w_shadow.top};
  assign w_b = {1'b0, w_shadow.bottom};

  // 11-bit compares keep thin boxes filled instead of wrapping.
  assign w_in_box = (w_x >= w_l) && (w_x <= w_r) &&
                    (w_y >= w_t) && (w_y <= w_b);
  assign w_edge   = (w_x < w_l + LW) || (w_x + LW > w_r) ||
                    (w_y < w_t + LW) || (w_y + LW > w_b);

`ifdef BBOX_OVERLAY_CROSSHAIR_EN
  logic [10:0] w_cx, w_cy;
  logic        w_cross;

  assign w_cx    = (w_l + w_r) >> 1;
  assign w_cy    = (w_t + w_b) >> 1;
  assign w_cross = ((w_y == w_cy) && (w_x + 11'd8 >= w_cx) &&
                    (w_x <= w_cx + 11'd8)) ||
                   ((w_x == w_cx) && (w_y + 11'd8 >= w_cy) &&
                    (w_y <= w_cy + 11'd8));
  assign w_paint = w_active && w_in_box && (w_edge || w_cross);
`else
  assign w_paint = w_active && w_in_box && w_edge;
`endif

  // One-cycle registered pixel output.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_out <= 12'h000;
    end else begin
      r_out <= w_paint ? BOX_COLOR : img_data;
    end
  end

  assign out_data   = r_out;
  assign box_active = w_active;
  assign miss_cnt   = w_miss;

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed self-checking bench for bbox_overlay.
// Frame end is forced by driving pixel (639,479) directly.
module tb_bbox_overlay;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] img_data;
  logic [9:0]  left, right, top, bottom;
  logic [11:0] out_data;
  logic        box_active;
  logic [3:0]  miss_cnt;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] img;
    logic [11:0] exp;
  } vec_t;

  vec_t tv[15];

  always #5 vga_clk = ~vga_clk;

  bbox_overlay dut (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .img_data  (img_data),
    .left      (left),
    .right     (right),
    .top       (top),
    .bottom    (bottom),
    .out_data  (out_data),
    .box_active(box_active),
    .miss_cnt  (miss_cnt)
  );

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y,
                    input logic [11:0] d);
    @(negedge vga_clk);
    pixel_x  = x;
    pixel_y  = y;
    img_data = d;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_box(input logic [9:0] l, input logic [9:0] r,
                         input logic [9:0] t, input logic [9:0] b);
    left   = l;
    right  = r;
    top    = t;
    bottom = b;
  endtask

  task automatic frame_end(input logic [9:0] l, input logic [9:0] r,
                           input logic [9:0] t, input logic [9:0] b);
    set_box(l, r, t, b);
    px(10'd639, 10'd479, 12'h000);
  endtask

  initial begin
    tv[0]  = '{10'd100, 10'd60,  12'h123, 12'hF00};
    tv[1]  = '{10'd101, 10'd60,  12'h124, 12'hF00};
    tv[2]  = '{10'd102, 10'd60,  12'h456, 12'h456};
    tv[3]  = '{10'd103, 10'd60,  12'hABC, 12'hABC};
    tv[4]  = '{10'd198, 10'd60,  12'h0F0, 12'h0F0};
    tv[5]  = '{10'd199, 10'd60,  12'h0F1, 12'hF00};
    tv[6]  = '{10'd200, 10'd60,  12'h0F2, 12'hF00};
    tv[7]  = '{10'd201, 10'd60,  12'h777, 12'h777};
    tv[8]  = '{10'd99,  10'd60,  12'h111, 12'h111};
    tv[9]  = '{10'd150, 10'd50,  12'h201, 12'hF00};
    tv[10] = '{10'd150, 10'd51,  12'h202, 12'hF00};
    tv[11] = '{10'd150, 10'd52,  12'h222, 12'h222};
    tv[12] = '{10'd150, 10'd149, 12'h203, 12'hF00};
    tv[13] = '{10'd150, 10'd150, 12'h204, 12'hF00};
    tv[14] = '{10'd150, 10'd151, 12'h333, 12'h333};

    rst      = 1'b1;
    pixel_x  = 10'd0;
    pixel_y  = 10'd0;
    img_data = 12'h000;
    set_box(10'd0, 10'd0, 10'd0, 10'd0);
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_out", out_data, 12'h000);
    chk("rst_active", {11'd0, box_active}, 12'h000);
    chk("rst_miss", {8'd0, miss_cnt}, 12'h000);
    @(negedge vga_clk);
    rst = 1'b0;

    px(10'd5, 10'd5, 12'hABC);
    chk("idle_pass", out_data, 12'hABC);

    frame_end(10'd100, 10'd640, 10'd10, 10'd20);
    chk("inv_right", {11'd0, box_active}, 12'h000);
    frame_end(10'd100, 10'd200, 10'd10, 10'd480);
    chk("inv_bottom", {11'd0, box_active}, 12'h000);
    frame_end(10'd100, 10'd100, 10'd10, 10'd20);
    chk("inv_lr_eq", {11'd0, box_active}, 12'h000);
    px(10'd0, 10'd0, 12'h321);
    chk("idle_no_draw", out_data, 12'h321);

    frame_end(10'd100, 10'd200, 10'd50, 10'd150);
    chk("track_active", {11'd0, box_active}, 12'h001);
    chk("track_miss", {8'd0, miss_cnt}, 12'h000);

    for (int i = 0; i < 15; i++) begin
      px(tv[i].x, tv[i].y, tv[i].img);
      chk($sformatf("vec%0d", i), out_data, tv[i].exp);
    end

    set_box(10'd300, 10'd400, 10'd300, 10'd400);
    px(10'd320, 10'd240, 12'h555);
    chk("mid_a", out_data, 12'h555);
    px(10'd100, 10'd60, 12'h001);
    chk("mid_old", out_data, 12'hF00);
    px(10'd350, 10'd300, 12'h002);
    chk("mid_new_hidden", out_data, 12'h002);
    frame_end(10'd300, 10'd400, 10'd300, 10'd400);
    px(10'd0, 10'd0, 12'h003);
    chk("nf_origin", out_data, 12'h003);
    px(10'd350, 10'd300, 12'h002);
    chk("nf_new", out_data, 12'hF00);
    px(10'd100, 10'd60, 12'h001);
    chk("nf_old_gone", out_data, 12'h001);

    for (int k = 1; k <= 3; k++) begin
      frame_end(10'd300, 10'd200, 10'd300, 10'd400);
      chk($sformatf("hold_miss%0d", k), {8'd0, miss_cnt}, 12'(k));
      chk($sformatf("hold_act%0d", k), {11'd0, box_active}, 12'h001);
      px(10'd350, 10'd300, 12'h004);
      chk($sformatf("hold_draw%0d", k), out_data, 12'hF00);
    end
    frame_end(10'd300, 10'd400, 10'd300, 10'd400);
    chk("retrack_miss", {8'd0, miss_cnt}, 12'h000);
    chk("retrack_act", {11'd0, box_active}, 12'h001);

    for (int k = 1; k <= 8; k++) begin
      frame_end(10'd300, 10'd200, 10'd300, 10'd400);
      if (k < 8) begin
        chk($sformatf("drop_miss%0d", k), {8'd0, miss_cnt}, 12'(k));
        chk($sformatf("drop_act%0d", k), {11'd0, box_active}, 12'h001);
      end else begin
        chk("drop_idle_miss", {8'd0, miss_cnt}, 12'h000);
        chk("drop_idle_act", {11'd0, box_active}, 12'h000);
      end
    end
    @(negedge vga_clk);
    pixel_x  = 10'd350;
    pixel_y  = 10'd300;
    img_data = 12'h6AB;
    #1;
    chk("lat_pre", out_data, 12'h000);
    @(posedge vga_clk);
    #1;
    chk("lat_post", out_data, 12'h6AB);

    frame_end(10'd10, 10'd12, 10'd10, 10'd12);
    for (int y = 10; y <= 12; y++) begin
      for (int x = 10; x <= 12; x++) begin
        px(10'(x), 10'(y), 12'h0AA);
        chk($sformatf("small_%0d_%0d", x, y), out_data, 12'hF00);
      end
    end
    px(10'd13, 10'd11, 12'h0BB);
    chk("small_right_out", out_data, 12'h0BB);
    px(10'd11, 10'd9, 12'h0CC);
    chk("small_top_out", out_data, 12'h0CC);

    frame_end(10'd0, 10'd639, 10'd0, 10'd479);
    px(10'd0, 10'd200, 12'h007);
    chk("full_l0", out_data, 12'hF00);
    px(10'd1, 10'd200, 12'h007);
    chk("full_l1", out_data, 12'hF00);
    px(10'd2, 10'd200, 12'h007);
    chk("full_l2", out_data, 12'h007);
    px(10'd639, 10'd200, 12'h007);
    chk("full_r", out_data, 12'hF00);
    px(10'd320, 10'd479, 12'h007);
    chk("full_b", out_data, 12'hF00);
    px(10'd320, 10'd240, 12'h006);
    chk("full_mid", out_data, 12'h006);

    px(10'd0, 10'd200, 12'h007);
    chk("pre_rst", out_data, 12'hF00);
    @(negedge vga_clk);
    rst = 1'b1;
    #1;
    chk("arst_out", out_data, 12'h000);
    chk("arst_act", {11'd0, box_active}, 12'h000);
    @(posedge vga_clk);
    #1;
    @(negedge vga_clk);
    rst = 1'b0;
    px(10'd0, 10'd200, 12'h007);
    chk("post_rst_idle", out_data, 12'h007);
    frame_end(10'd0, 10'd639, 10'd0, 10'd479);
    chk("post_rst_track", {11'd0, box_active}, 12'h001);
    px(10'd0, 10'd200, 12'h007);
    chk("post_rst_draw", out_data, 12'hF00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bbox_overlay.md
BBOX_OVERLAY -- requirements
Module: bbox_overlay

Interface
REQ-001 Parameter LINE_W, default 2: box outline thickness in pixels (1..8).
REQ-002 Parameter BOX_COLOR, default 12'hF00: RGB444 colour written on outline pixels.
REQ-003 Parameter HOLD_FRAMES, default 8: consecutive invalid frames tolerated before the box is dropped (1..15).
REQ-004 vga_clk  in  1  pixel clock; sole clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pixel_x  in  10  current pixel column, 0..639.
REQ-007 pixel_y  in  10  current pixel row, 0..479.
REQ-008 img_data  in  12  RGB444 pixel to be displayed.
REQ-009 left, right, top, bottom  in  10 each  bounding box from the centroid/boundary block.
REQ-010 out_data  out  12  displayed pixel, overlay applied.
REQ-011 box_active  out  1  high while a box is being drawn (TRACK or HOLD).
REQ-012 miss_cnt  out  4  consecutive invalid frames counted in HOLD.

Function
REQ-013 Frame end SHALL be the cycle with pixel_x==639 and pixel_y==479.
REQ-014 left/right/top/bottom SHALL be sampled only at frame end into a capture set; the drawn (shadow) set changes only at frame end, never mid-frame.
REQ-015 A capture SHALL be valid iff left<right, top<bottom, right<=639 and bottom<=479.
REQ-016 A valid capture SHALL be copied into the shadow set in the same frame-end cycle; an invalid capture SHALL leave the shadow set unchanged.
REQ-017 State machine IDLE/TRACK/HOLD, transitions only at frame end: IDLE->TRACK on valid; TRACK->HOLD on invalid; HOLD->TRACK on valid; HOLD->IDLE when miss_cnt would reach HOLD_FRAMES; otherwise stay.
REQ-018 miss_cnt SHALL clear on entering TRACK or IDLE and increment by one at each invalid frame end in HOLD/entry into HOLD (TRACK->HOLD sets it to 1).
REQ-019 Outline pixel: left<=x<=right, top<=y<=bottom, and (x<left+LINE_W or x+LINE_W>right or y<top+LINE_W or y+LINE_W>bottom); comparisons in 11-bit unsigned, no wrap.
REQ-020 out_data SHALL be registered, latency exactly 1 cycle from pixel_x/pixel_y/img_data.
REQ-021 out_data SHALL equal BOX_COLOR for outline pixels when box_active, else img_data.
REQ-022 Box thinner than 2*LINE_W SHALL render fully filled, not wrapped.
REQ-023 box_active SHALL be registered and reflect the state after the frame-end transition.

Reset
REQ-024 rst asserted: state IDLE, shadow set left=top=0, right=639, bottom=479, out_data=12'h000, box_active=0, miss_cnt=0.
REQ-025 rst mid-frame SHALL take effect immediately; first capture after release occurs at the next frame end.

Configuration
REQ-026 Macro BBOX_OVERLAY_CROSSHAIR_EN defined: additionally paint BOX_COLOR on a 1-pixel crosshair of half-length 8 centred at ((left+right)>>1, (top+bottom)>>1) of the shadow set, clipped to the box; undefined: no crosshair logic, outline only.

Structure
REQ-027 Shared package SHALL hold H_ACTIVE=640, V_ACTIVE=480, the IDLE/TRACK/HOLD state encoding and the RGB444 pixel type.
REQ-028 One sub-module bbox_capture SHALL contain frame-end detect, validity check, capture/shadow registers and the state machine; the top holds the pixel-compare datapath.

Verification
REQ-029 After reset, box 100/200/50/150 valid at frame end -> next frame: pixel (100,60) = 12'hF00, (103,60) = img_data, box_active=1.
REQ-030 Box changed mid-frame (x=320,y=240) -> current-frame output unchanged; new box visible only from pixel (0,0) of next frame.
REQ-031 TRACK, then left=300,right=200 for 3 frames -> old box still drawn, miss_cnt 1,2,3; then valid -> TRACK, miss_cnt=0.
REQ-032 Invalid for HOLD_FRAMES=8 frames -> IDLE after 8th frame end, box_active=0, out_data==img_data delayed 1 cycle.
REQ-033 Box 10/12/10/12 with LINE_W=2 -> all 9 interior pixels BOX_COLOR; right=639,bottom=479 valid, left=0 edge drawn.
REQ-034 rst pulse mid-frame in TRACK -> out_data=0 asynchronously; after release IDLE until next valid frame end.
